apb4_reg_bridge: RTL and testbench

//  APB4 slave front end for the CSR/register-map block. Converts each APB4 access

---
 rtl/apb4_reg_bridge.sv | 177 +++++++++++++++++
 tb/tb_apb4_reg_bridge.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/apb4_reg_bridge.sv
// APB4 slave front end that turns each APB access into one register-bus
// request, waits for the register map's reply and completes the APB transfer.
// All outputs come straight from flops; one transaction is in flight at most.
module apb4_reg_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr,
  output logic                    bus_req,
  output logic                    bus_req_is_wr,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wr_data,
  output logic [DATA_WIDTH-1:0]   bus_wr_biten,
  output logic                    bus_req_stall_wr,
  output logic                    bus_req_stall_rd,
  input  logic                    bus_ready,
  input  logic                    bus_err,
  input  logic [DATA_WIDTH-1:0]   bus_rd_data
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB_W  = (STRB_W > 1) ? $clog2(STRB_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Expand byte strobes to a per-bit write enable mask.
  function automatic logic [DATA_WIDTH-1:0] expand_strb(input logic [STRB_W-1:0] s);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < STRB_W; i++) begin
      r[i*8 +: 8] = {8{s[i]}};
    end
    return r;
  endfunction

  state_t                  state_q, state_d;
  logic                    bus_req_q, bus_req_d;
  logic                    is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   biten_q, biten_d;
  logic                    stall_wr_q, stall_wr_d;
  logic                    stall_rd_q, stall_rd_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;

  logic access;
  logic misaligned;
  logic unused_pprot;

  assign access       = psel & penable;
  // Byte addresses must fall on a full data-word boundary.
  assign misaligned   = (STRB_W > 1) ? (paddr[LSB_W-1:0] != '0) : 1'b0;
  // Protection attributes carry no meaning for the register map.
  assign unused_pprot = ^pprot;

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_d    = state_q;
    bus_req_d  = 1'b0;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    biten_d    = biten_q;
    stall_wr_d = stall_wr_q;
    stall_rd_d = stall_rd_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (misaligned) begin
            // Rejected locally: the register map never sees this access.
            state_d   = S_RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else begin
            state_d   = S_REQ;
            bus_req_d = 1'b1;
            is_wr_d   = pwrite;
            addr_d    = paddr;
            wdata_d   = pwrite ? pwdata : '0;
            biten_d   = pwrite ? expand_strb(pstrb) : '0;
          end
        end
      end

      S_REQ, S_WAIT: begin
        if (bus_ready) begin
          // pready only if the master is still waiting on this transfer.
          state_d    = S_RESP;
          stall_wr_d = 1'b0;
          stall_rd_d = 1'b0;
          pready_d   = access;
          pslverr_d  = bus_err;
          prdata_d   = is_wr_q ? '0 : bus_rd_data;
        end else begin
          state_d    = S_WAIT;
          stall_wr_d = is_wr_q;
          stall_rd_d = !is_wr_q;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
        is_wr_d = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        biten_d = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register state and every output; reset drops any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bus_req_q  <= 1'b0;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      biten_q    <= '0;
      stall_wr_q <= 1'b0;
      stall_rd_q <= 1'b0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      bus_req_q  <= bus_req_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      biten_q    <= biten_d;
      stall_wr_q <= stall_wr_d;
      stall_rd_q <= stall_rd_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
    end
  end

  assign pready           = pready_q;
  assign pslverr          = pslverr_q;
  assign prdata           = prdata_q;
  assign bus_req          = bus_req_q;
  assign bus_req_is_wr    = is_wr_q;
  assign bus_addr         = addr_q;
  assign bus_wr_data      = wdata_q;
  assign bus_wr_biten     = biten_q;
  assign bus_req_stall_wr = stall_wr_q;
  assign bus_req_stall_rd = stall_rd_q;

endmodule

// File: tb/tb_apb4_reg_bridge.sv
// Bench for apb4_reg_bridge: APB master driver, register-map responder with
// programmable reply delay/error, and a word-array model of the register map.
module tb_apb4_reg_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [10:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [2:0]  pprot = '0;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        bus_req;
  logic        bus_req_is_wr;
  logic [10:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_wr_biten;
  logic        bus_req_stall_wr;
  logic        bus_req_stall_rd;
  logic        bus_ready = 1'b0;
  logic        bus_err = 1'b0;
  logic [31:0] bus_rd_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference contents (from stimulus) and the peer's contents (from DUT requests).
  logic [31:0] ref_mem [512];
  logic [31:0] map_mem [512];

  int rsp_delay = 0;
  bit rsp_err   = 1'b0;

  apb4_reg_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .bus_req(bus_req), .bus_req_is_wr(bus_req_is_wr), .bus_addr(bus_addr),
    .bus_wr_data(bus_wr_data), .bus_wr_biten(bus_wr_biten),
    .bus_req_stall_wr(bus_req_stall_wr), .bus_req_stall_rd(bus_req_stall_rd),
    .bus_ready(bus_ready), .bus_err(bus_err), .bus_rd_data(bus_rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Register-map peer: replies rsp_delay cycles after bus_req; noise on the reply lines otherwise.
  bit          pend = 1'b0;
  int          wleft = 0;
  bit          p_wr, p_err;
  logic [10:0] p_addr;
  logic [31:0] p_data, p_biten;
  always @(negedge clk) begin
    bus_ready   = $urandom_range(0, 1);
    bus_err     = $urandom_range(0, 1);
    bus_rd_data = $urandom;
    if (bus_req) begin
      pend    = 1'b1;
      wleft   = rsp_delay;
      p_err   = rsp_err;
      p_wr    = bus_req_is_wr;
      p_addr  = bus_addr;
      p_data  = bus_wr_data;
      p_biten = bus_wr_biten;
    end
    if (pend) begin
      bus_ready = 1'b0;
      if (wleft == 0) begin
        bus_ready = 1'b1;
        bus_err   = p_err;
        if (!p_wr) bus_rd_data = map_mem[p_addr[10:2]];
        else if (!p_err) map_mem[p_addr[10:2]] = (map_mem[p_addr[10:2]] & ~p_biten) | (p_data & p_biten);
        pend = 1'b0;
      end else begin
        wleft--;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk(tag, {pready, pslverr, prdata, bus_req, bus_req_is_wr, bus_addr,
              bus_wr_data, bus_wr_biten, bus_req_stall_wr, bus_req_stall_rd}, '0);
  endtask

  // One APB transfer, checked cycle by cycle against the spec's timing rules.
  task automatic apb_xfer(input bit wr, input logic [10:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int d, input bit err, input bit abandon);
    bit          mis;
    int          lat;
    logic [31:0] eb, exp_rd;
    bit          exp_err, act, stall;
    mis = (addr[1:0] != 2'b00);
    lat = mis ? 1 : 2 + d;
    eb  = '0;
    for (int i = 0; i < 4; i++) if (strb[i]) eb[i*8 +: 8] = 8'hFF;
    exp_rd  = (mis || wr) ? 32'h0 : ref_mem[addr[10:2]];
    exp_err = mis ? 1'b1 : err;
    rsp_delay = d;
    rsp_err   = err;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = data; pstrb = strb; pprot = 3'($urandom);
    @(negedge clk);
    penable = 1'b1;
    for (int n = 1; n <= lat + 1; n++) begin
      @(posedge clk); #1;
      act   = !mis && (n <= lat);
      stall = !mis && (n >= 2) && (n <= 1 + d);
      chk("bus_req", bus_req, !mis && n == 1);
      chk("is_wr", bus_req_is_wr, act ? wr : 1'b0);
      chk("bus_addr", bus_addr, act ? addr : 11'h0);
      chk("biten", bus_wr_biten, (act && wr) ? eb : 32'h0);
      if (wr || !act) chk("wr_data", bus_wr_data, act ? data : 32'h0);
      chk("stall_wr", bus_req_stall_wr, stall && wr);
      chk("stall_rd", bus_req_stall_rd, stall && !wr);
      if (n == lat && !abandon) begin
        chk("pready", pready, 1'b1);
        chk("prdata", prdata, exp_rd);
        chk("pslverr", pslverr, exp_err);
      end else if (n == lat) begin
        chk("pready_abandoned", pready, 1'b0);
      end else begin
        chk("pready_idle", pready, 1'b0);
        chk("prdata_idle", prdata, 32'h0);
        chk("pslverr_idle", pslverr, 1'b0);
      end
      if (abandon && n == 1) begin
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
      end
    end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    if (!mis && wr && !err)
      ref_mem[addr[10:2]] = (ref_mem[addr[10:2]] & ~eb) | (data & eb);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      ref_mem[i] = $urandom;
      map_mem[i] = ref_mem[i];
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset_outputs");
    @(negedge clk) rst = 1'b0;

    // Directed cases
    apb_xfer(1'b1, 11'h010, 32'hDEADBEEF, 4'b1111, 0, 1'b0, 1'b0);
    apb_xfer(1'b1, 11'h024, 32'h12345678, 4'b1111, 1, 1'b0, 1'b0);
    apb_xfer(1'b0, 11'h024, 32'h0, 4'b0000, 3, 1'b0, 1'b0);
    apb_xfer(1'b0, 11'h010, 32'h0, 4'b0000, 0, 1'b0, 1'b0);
    apb_xfer(1'b1, 11'h030, 32'hA5A5C3C3, 4'b0101, 2, 1'b0, 1'b0);
    apb_xfer(1'b0, 11'h030, 32'h0, 4'b0000, 1, 1'b0, 1'b0);
    apb_xfer(1'b0, 11'h040, 32'h0, 4'b0000, 2, 1'b1, 1'b0);
    apb_xfer(1'b1, 11'h013, 32'h11111111, 4'b1111, 0, 1'b0, 1'b0);
    apb_xfer(1'b1, 11'h044, 32'hFFFFFFFF, 4'b0000, 0, 1'b0, 1'b0);
    apb_xfer(1'b1, 11'h048, 32'hCAFEF00D, 4'b1111, 3, 1'b0, 1'b1);
    apb_xfer(1'b0, 11'h048, 32'h0, 4'b0000, 0, 1'b0, 1'b0);

    // Reset while waiting on a read: outputs clear, the late reply is ignored
    rsp_delay = 6; rsp_err = 1'b0;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 11'h050;
    @(negedge clk) penable = 1'b1;
    @(posedge clk); #1 chk("rst_test_req", bus_req, 1'b1);
    @(posedge clk); #1 chk("rst_test_stall", bus_req_stall_rd, 1'b1);
    @(negedge clk);
    rst = 1'b1; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1 check_all_zero("rst_in_wait");
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 check_all_zero("late_ready_ignored");
    end
    apb_xfer(1'b0, 11'h010, 32'h0, 4'b0000, 1, 1'b0, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 150; k++) begin
      bit          wr, err, ab;
      logic [10:0] a;
      int          d;
      wr  = 1'($urandom);
      a   = 11'($urandom);
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      d   = $urandom_range(0, 4);
      err = ($urandom_range(0, 5) == 0);
      ab  = (a[1:0] == 2'b00) && ($urandom_range(0, 9) == 0);
      apb_xfer(wr, a, $urandom, 4'($urandom), d, err, ab);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
